// File: rtl/pmem_responder_if.sv
// Cache-to-memory line interface: level requests from the cache, one-cycle completion from memory.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // Cache controller / datapath side
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // Memory side
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder serving 128-bit line fills and writebacks.
module pmem_responder #(
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pmem_responder_if.slave      bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned DEPTH  = 2 ** IDX_BITS;
  localparam int unsigned LAT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  op_wr;
  logic [IDX_BITS-1:0]   op_idx;
  logic [LINE_W-1:0]     op_wdata;
  logic [LINE_W-1:0]     mem [DEPTH];

  logic                  accept_c;
  logic                  enter_resp_c;
  logic                  resp_d;
  logic                  busy_d;
  logic                  cur_wr_c;
  logic [IDX_BITS-1:0]   cur_idx_c;
  logic [LINE_W-1:0]     cur_wdata_c;
  logic [IDX_BITS-1:0]   req_idx;
  logic                  addr_unused;

  // Line index decode; offset and upper address bits do not select storage
  assign req_idx     = bus.pmem_address[IDX_BITS+3:4];
  assign addr_unused = ^{bus.pmem_address[15:IDX_BITS+4], bus.pmem_address[3:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; requests are only taken in IDLE
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          accept_c   = 1'b1;
          next_state = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (lat_cnt == LAT_W'(1)) begin
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode; with LATENCY=1 the live request bypasses the capture registers
  always_comb begin
    resp_d       = (next_state == S_RESP);
    busy_d       = (next_state != S_IDLE);
    enter_resp_c = (next_state == S_RESP);
    cur_wr_c     = op_wr;
    cur_idx_c    = op_idx;
    cur_wdata_c  = op_wdata;
    if (accept_c) begin
      cur_wr_c    = bus.pmem_write;
      cur_idx_c   = req_idx;
      cur_wdata_c = bus.pmem_wdata;
    end
  end

  // Request capture and latency countdown; write wins over a simultaneous read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_cnt  <= '0;
      op_wr    <= 1'b0;
      op_idx   <= '0;
      op_wdata <= '0;
    end else if (accept_c) begin
      lat_cnt  <= LAT_W'(LATENCY - 1);
      op_wr    <= bus.pmem_write;
      op_idx   <= req_idx;
      op_wdata <= bus.pmem_wdata;
    end else if (state == S_BUSY) begin
      lat_cnt  <= lat_cnt - LAT_W'(1);
    end
  end

  // Line storage; committed on the edge entering RESP, never cleared by reset
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp_c && cur_wr_c) begin
      mem[cur_idx_c] <= cur_wdata_c;
    end
  end

  // Registered outputs: response pulse, busy, fill data and saturating counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.pmem_resp  <= 1'b0;
      bus.pmem_rdata <= '0;
      busy           <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      bus.pmem_resp <= resp_d;
      busy          <= busy_d;
      if (enter_resp_c && !cur_wr_c) begin
        bus.pmem_rdata <= mem[cur_idx_c];
      end
      if (state == S_RESP) begin
        if (op_wr) begin
          if (wr_count != {CNT_WIDTH{1'b1}}) wr_count <= wr_count + CNT_WIDTH'(1);
        end else begin
          if (rd_count != {CNT_WIDTH{1'b1}}) rd_count <= rd_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: directed transactions, expected responses queued per DUT.
module tb_pmem_responder;

  localparam int unsigned LAT0 = 8;
  localparam int unsigned LAT1 = 1;

  localparam logic [127:0] DATA_A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DATA_B1 = 128'hB1B1_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DATA_B2 = 128'hB2B2_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
  localparam logic [127:0] DATA_C  = 128'hCCCC_0123_CCCC_4567_CCCC_89AB_CCCC_CDEF;
  localparam logic [127:0] DATA_L3 = 128'h3333_3333_0000_0000_3333_3333_0000_0003;
  localparam logic [127:0] DATA_L4 = 128'h4444_4444_0000_0000_4444_4444_0000_0004;
  localparam logic [127:0] DATA_O  = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
  localparam logic [127:0] DATA_D  = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
  localparam logic [127:0] DATA_E  = 128'hE0E1_E2E3_E4E5_E6E7_E8E9_EAEB_ECED_EEEF;

  typedef struct {
    int unsigned  cyc;
    bit           is_rd;
    logic [127:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        rst1_n;
  logic        busy0, busy1;
  logic [15:0] rdc0, wrc0;
  logic [1:0]  rdc1, wrc1;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  pmem_responder_if bus0();
  pmem_responder_if bus1();

  pmem_responder #(.LATENCY(LAT0), .IDX_BITS(6), .CNT_WIDTH(16)) dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus0),
    .busy     (busy0),
    .rd_count (rdc0),
    .wr_count (wrc0)
  );

  pmem_responder #(.LATENCY(LAT1), .IDX_BITS(6), .CNT_WIDTH(2)) dut1 (
    .clk      (clk),
    .reset_n  (rst1_n),
    .bus      (bus1),
    .busy     (busy1),
    .rd_count (rdc1),
    .wr_count (wrc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor for the LATENCY=8 instance
  always @(negedge clk) begin
    exp_t e;
    if (bus0.pmem_resp === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_resp: got resp at cycle %0d required none", cyc);
      end else begin
        e = q0.pop_front();
        check("dut0_resp_cycle", 128'(cyc), 128'(e.cyc));
        if (e.is_rd) check("dut0_rdata", bus0.pmem_rdata, e.data);
      end
    end
  end

  // Monitor for the LATENCY=1 instance
  always @(negedge clk) begin
    exp_t e;
    if (bus1.pmem_resp === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_resp: got resp at cycle %0d required none", cyc);
      end else begin
        e = q1.pop_front();
        check("dut1_resp_cycle", 128'(cyc), 128'(e.cyc));
        if (e.is_rd) check("dut1_rdata", bus1.pmem_rdata, e.data);
      end
    end
  end

  // One transaction on dut0, request held until the response cycle
  task automatic req0(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [127:0] wd, input logic [127:0] exp_rd);
    exp_t e;
    bit   got;
    @(negedge clk);
    bus0.pmem_read    = rd;
    bus0.pmem_write   = wr;
    bus0.pmem_address = addr;
    bus0.pmem_wdata   = wd;
    @(posedge clk);
    #1;
    e.cyc   = cyc + LAT0 - 1;
    e.is_rd = rd && !wr;
    e.data  = exp_rd;
    q0.push_back(e);
    got = 1'b0;
    for (int n = 0; n < int'(LAT0) + 16; n++) begin
      @(negedge clk);
      if (bus0.pmem_resp === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL dut0_resp_timeout: got no resp for addr %h required one", addr);
    end
    bus0.pmem_read  = 1'b0;
    bus0.pmem_write = 1'b0;
  endtask

  task automatic check_cnt0(input logic [15:0] rd, input logic [15:0] wr);
    @(negedge clk);
    check("dut0_rd_count", 128'(rdc0), 128'(rd));
    check("dut0_wr_count", 128'(wrc0), 128'(wr));
    check("dut0_idle_busy", 128'(busy0), 128'(0));
  endtask

  // Held request on dut1 spanning n back-to-back transactions
  task automatic held1(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int n, input logic [127:0] exp_rd);
    exp_t        e;
    int unsigned c;
    @(negedge clk);
    c = cyc;
    bus1.pmem_read    = rd;
    bus1.pmem_write   = wr;
    bus1.pmem_address = addr;
    bus1.pmem_wdata   = wd;
    for (int i = 0; i < n; i++) begin
      e.cyc   = c + 1 + 2 * i;
      e.is_rd = rd && !wr;
      e.data  = exp_rd;
      q1.push_back(e);
    end
    repeat (2 * n - 1) @(negedge clk);
    bus1.pmem_read  = 1'b0;
    bus1.pmem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned k;
    reset_n = 1'b0;
    rst1_n  = 1'b0;
    bus0.pmem_read = 1'b0; bus0.pmem_write = 1'b0; bus0.pmem_address = '0; bus0.pmem_wdata = '0;
    bus1.pmem_read = 1'b0; bus1.pmem_write = 1'b0; bus1.pmem_address = '0; bus1.pmem_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_resp",  128'(bus0.pmem_resp), 128'(0));
    check("rst_busy",  128'(busy0), 128'(0));
    check("rst_rdata", bus0.pmem_rdata, 128'(0));
    check("rst_rd_count", 128'(rdc0), 128'(0));
    check("rst_wr_count", 128'(wrc0), 128'(0));
    check("rst1_counts", 128'({rdc1, wrc1}), 128'(0));
    reset_n = 1'b1;
    rst1_n  = 1'b1;

    // Write then read line 5
    req0(1'b0, 1'b1, 16'h0050, DATA_A, '0);
    req0(1'b1, 1'b0, 16'h0050, '0, DATA_A);
    check_cnt0(16'd1, 16'd1);

    // Aliasing on upper bits and low nibble; fill data holds across writes
    req0(1'b0, 1'b1, 16'h0050, DATA_B1, '0);
    check("rdata_hold_on_write", bus0.pmem_rdata, DATA_A);
    req0(1'b0, 1'b1, 16'h1050, DATA_B2, '0);
    req0(1'b1, 1'b0, 16'h0050, '0, DATA_B2);
    req0(1'b1, 1'b0, 16'h005F, '0, DATA_B2);
    check_cnt0(16'd3, 16'd3);

    // Simultaneous read and write is a write
    req0(1'b1, 1'b1, 16'h0020, DATA_C, '0);
    check_cnt0(16'd3, 16'd4);
    req0(1'b1, 1'b0, 16'h0020, '0, DATA_C);

    // Mid-operation input churn
    req0(1'b0, 1'b1, 16'h0030, DATA_L3, '0);
    req0(1'b0, 1'b1, 16'h0040, DATA_L4, '0);
    check_cnt0(16'd4, 16'd6);
    @(negedge clk);
    bus0.pmem_read    = 1'b1;
    bus0.pmem_address = 16'h0030;
    @(posedge clk);
    #1;
    k = cyc;
    q0.push_back('{cyc: k + LAT0 - 1, is_rd: 1'b1, data: DATA_L3});
    for (int i = 0; i < int'(LAT0); i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus0.pmem_read    = 1'b0;
        bus0.pmem_address = 16'h0040;
        bus0.pmem_wdata   = DATA_D;
      end
      check("churn_busy_inflight", 128'(busy0), 128'(1));
    end
    check_cnt0(16'd5, 16'd6);

    // Reset in the middle of a write
    req0(1'b0, 1'b1, 16'h0070, DATA_O, '0);
    @(negedge clk);
    bus0.pmem_write   = 1'b1;
    bus0.pmem_address = 16'h0070;
    bus0.pmem_wdata   = DATA_D;
    @(posedge clk);
    #1;
    repeat (4) @(negedge clk);
    reset_n         = 1'b0;
    bus0.pmem_write = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy0), 128'(0));
    check("midrst_resp", 128'(bus0.pmem_resp), 128'(0));
    check("midrst_counts", 128'({rdc0, wrc0}), 128'(0));
    check("midrst_rdata", bus0.pmem_rdata, 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    req0(1'b1, 1'b0, 16'h0070, '0, DATA_O);
    check_cnt0(16'd1, 16'd0);

    // LATENCY=1: held requests every 2 cycles, 2-bit counters saturate
    held1(1'b0, 1'b1, 16'h0010, DATA_E, 5, '0);
    @(negedge clk);
    check("dut1_wr_sat", 128'(wrc1), 128'(3));
    check("dut1_rd_zero", 128'(rdc1), 128'(0));
    held1(1'b1, 1'b0, 16'h0010, '0, 4, DATA_E);
    @(negedge clk);
    check("dut1_rd_sat", 128'(rdc1), 128'(3));
    check("dut1_wr_hold", 128'(wrc1), 128'(3));

    repeat (LAT0 + 4) @(negedge clk);
    check("dut0_queue_drained", 128'(q0.size()), 128'(0));
    check("dut1_queue_drained", 128'(q1.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
